// File: rtl/simd_issue_ctrl_if.sv
// Micro-op issue and writeback handshake bundle for the MMX SIMD issue slot.
// The master side is the front end and writeback consumer; the slave side is simd_issue_ctrl.
interface simd_issue_ctrl_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned OP_W   = 3;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_dst;
  logic [REG_W-1:0]  in_src;
  logic              in_src_is_mem;
  logic [DATA_W-1:0] in_mem_data;

  logic              out_valid;
  logic              out_ready;
  logic [REG_W-1:0]  out_dst;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_op, in_dst, in_src, in_src_is_mem, in_mem_data, out_ready,
    input  in_ready, out_valid, out_dst, out_data
  );

  modport slave (
    input  in_valid, in_op, in_dst, in_src, in_src_is_mem, in_mem_data, out_ready,
    output in_ready, out_valid, out_dst, out_data
  );
endinterface

// File: rtl/simd_issue_ctrl.sv
// Single-entry MMX SIMD issue/writeback slot: operand fetch with result bypass,
// one-cycle capture of the external datapath result, illegal-op zeroing and writeback counting.
module simd_issue_ctrl (
  input  logic         clk,
  input  logic         reset,
  simd_issue_ctrl_if.slave bus,
  output logic [2:0]   rf_rd_a_addr,
  output logic [2:0]   rf_rd_b_addr,
  input  logic [63:0]  rf_rd_a_data,
  input  logic [63:0]  rf_rd_b_data,
  output logic [63:0]  simd_mm,
  output logic [63:0]  simd_mm64,
  output logic [2:0]   simd_op,
  input  logic [63:0]  simd_out,
  input  logic         flush,
  output logic         illegal_op,
  output logic [15:0]  op_count
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_MOVQ = OP_W'(4);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic [REG_W-1:0]   dst_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   count_q;

  logic               ready;
  logic               accept;
  logic               wb;
  logic               op_legal;
  logic               full;

  assign full     = (state_q == FULL);
  assign op_legal = (bus.in_op <= OP_MOVQ);

  // Slot handshake: flush and reset both block acceptance
  assign ready  = !reset && !flush && (!full || bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign wb     = full && bus.out_ready && !flush;

  // Operand fetch; the held result is the newest copy of its register
  assign rf_rd_a_addr = bus.in_dst;
  assign rf_rd_b_addr = bus.in_src;
  assign simd_op      = op_legal ? bus.in_op : OP_MOVQ;

  always_comb begin
    simd_mm = rf_rd_a_data;
    if (full && (dst_q == bus.in_dst)) simd_mm = data_q;
  end

  always_comb begin
    simd_mm64 = rf_rd_b_data;
    if (bus.in_src_is_mem)                  simd_mm64 = bus.in_mem_data;
    else if (full && (dst_q == bus.in_src)) simd_mm64 = data_q;
  end

  // Next-state logic; flush always empties the slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      dst_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= op_legal ? simd_out : '0;
        dst_q  <= bus.in_dst;
        if (!op_legal) illegal_q <= 1'b1;
      end
      if (wb) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = full;
  assign bus.out_dst   = dst_q;
  assign bus.out_data  = data_q;
  assign illegal_op    = illegal_q;
  assign op_count      = count_q;
endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Scoreboard bench for simd_issue_ctrl with a behavioural MMX register file and SIMD datapath.
module tb_simd_issue_ctrl;
  localparam logic [2:0] OP_PADDW = 3'd0;
  localparam logic [2:0] OP_PADDD = 3'd1;
  localparam logic [2:0] OP_PMAX  = 3'd2;
  localparam logic [2:0] OP_PMIN  = 3'd3;
  localparam logic [2:0] OP_MOVQ  = 3'd4;

  typedef struct {
    logic [2:0]  dst;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  rf_rd_a_addr, rf_rd_b_addr;
  logic [63:0] rf_rd_a_data, rf_rd_b_data;
  logic [63:0] simd_mm, simd_mm64, simd_out;
  logic [2:0]  simd_op;
  logic        illegal_op;
  logic [15:0] op_count;

  simd_issue_ctrl_if bus ();

  simd_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .rf_rd_a_addr (rf_rd_a_addr),
    .rf_rd_b_addr (rf_rd_b_addr),
    .rf_rd_a_data (rf_rd_a_data),
    .rf_rd_b_data (rf_rd_b_data),
    .simd_mm      (simd_mm),
    .simd_mm64    (simd_mm64),
    .simd_op      (simd_op),
    .simd_out     (simd_out),
    .flush        (flush),
    .illegal_op   (illegal_op),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference SIMD semantics; illegal codes produce zero
  function automatic logic [63:0] alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      OP_PADDW: for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
      OP_PADDD: for (int i = 0; i < 2; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      OP_PMAX:  for (int i = 0; i < 4; i++)
                  r[16*i +: 16] = ($signed(a[16*i +: 16]) > $signed(b[16*i +: 16])) ? a[16*i +: 16] : b[16*i +: 16];
      OP_PMIN:  for (int i = 0; i < 4; i++)
                  r[16*i +: 16] = ($signed(a[16*i +: 16]) < $signed(b[16*i +: 16])) ? a[16*i +: 16] : b[16*i +: 16];
      OP_MOVQ:  r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Harness register file and datapath
  logic [63:0] rf [8];
  logic [63:0] rf_init_vals [8];
  logic        rf_load;

  assign rf_rd_a_data = rf[rf_rd_a_addr];
  assign rf_rd_b_data = rf[rf_rd_b_addr];
  assign simd_out     = alu(simd_op, simd_mm, simd_mm64);

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init_vals[i];
    end else if (bus.out_valid && bus.out_ready && !reset && !flush) begin
      rf[bus.out_dst] <= bus.out_data;
    end
  end

  // Model state: slot occupancy, program-order register values, scoreboard
  logic        mon_en = 1'b0;
  logic        m_full = 1'b0;
  logic [2:0]  m_dst = '0;
  logic [15:0] m_count = '0;
  logic        m_illegal = 1'b0;
  logic [63:0] spec [8];
  exp_t        exp_q [$];

  always @(negedge clk) begin
    logic        mr, hs, acc;
    logic [63:0] ea, eb, r;
    exp_t        e;
    if (mon_en) begin
      if (rf_load) for (int i = 0; i < 8; i++) spec[i] = rf_init_vals[i];
      mr  = !reset && !flush && (!m_full || bus.out_ready);
      hs  = m_full && bus.out_ready && !reset && !flush;
      acc = bus.in_valid && mr;
      ea  = spec[bus.in_dst];
      eb  = bus.in_src_is_mem ? bus.in_mem_data : spec[bus.in_src];

      check("in_ready", 64'(bus.in_ready), 64'(mr));
      check("out_valid", 64'(bus.out_valid), 64'(m_full));
      check("op_count", 64'(op_count), 64'(m_count));
      check("illegal_op", 64'(illegal_op), 64'(m_illegal));
      if (bus.in_valid && !reset) begin
        check("simd_mm", simd_mm, ea);
        check("simd_mm64", simd_mm64, eb);
        check("simd_op", 64'(simd_op), 64'((bus.in_op > OP_MOVQ) ? OP_MOVQ : bus.in_op));
        check("rf_rd_a_addr", 64'(rf_rd_a_addr), 64'(bus.in_dst));
        check("rf_rd_b_addr", 64'(rf_rd_b_addr), 64'(bus.in_src));
      end

      if (m_full && (hs || reset || flush)) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          if (hs) begin
            check("wb_dst", 64'(bus.out_dst), 64'(e.dst));
            check("wb_data", bus.out_data, e.data);
          end else begin
            spec[m_dst] = rf[m_dst];
          end
        end
      end

      if (acc) begin
        r = alu(bus.in_op, ea, eb);
        e.dst  = bus.in_dst;
        e.data = r;
        exp_q.push_back(e);
        spec[bus.in_dst] = r;
        if (bus.in_op > OP_MOVQ) m_illegal = 1'b1;
        m_dst = bus.in_dst;
      end

      if (reset) begin
        m_full = 1'b0; m_count = '0; m_illegal = 1'b0; exp_q.delete();
      end else begin
        if (flush)    m_full = 1'b0;
        else if (acc) m_full = 1'b1;
        else if (hs)  m_full = 1'b0;
        if (hs) m_count = m_count + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] dst,
                       input logic [2:0] src, input logic mem, input logic [63:0] md);
    bus.in_valid      = v;
    bus.in_op         = op;
    bus.in_dst        = dst;
    bus.in_src        = src;
    bus.in_src_is_mem = mem;
    bus.in_mem_data   = md;
  endtask

  logic [63:0] exp1, exp6;
  int          guard;

  initial begin
    reset = 1'b1; flush = 1'b0; rf_load = 1'b1; bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) rf_init_vals[i] = {$urandom, $urandom};
    rf_init_vals[1] = 64'h0001_FFFF_7FFF_0010;
    rf_init_vals[2] = 64'h0001_0001_0001_0010;
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_out_dst", 64'(bus.out_dst), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_op_count", 64'(op_count), 64'h0);
    check("rst_illegal", 64'(illegal_op), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; rf_load = 1'b0;

    // paddw mm1 += mm2
    bus.out_ready = 1'b1;
    drive(1'b1, OP_PADDW, 3'd1, 3'd2, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("paddw_data", bus.out_data, 64'h0002_0000_8000_0020);
    check("paddw_dst", 64'(bus.out_dst), 64'd1);
    step();
    @(negedge clk);
    check("paddw_count", 64'(op_count), 64'd1);

    // paddd mm3 += mm4, then movq mm5 <- mm3 via bypass
    exp1 = alu(OP_PADDD, rf_init_vals[3], rf_init_vals[4]);
    drive(1'b1, OP_PADDD, 3'd3, 3'd4, 1'b0, '0);
    step();
    drive(1'b1, OP_MOVQ, 3'd5, 3'd3, 1'b0, '0);
    @(negedge clk);
    check("byp_mm64", simd_mm64, exp1);
    check("byp_first", bus.out_data, exp1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("byp_movq", bus.out_data, exp1);
    check("byp_dst", 64'(bus.out_dst), 64'd5);
    step();

    // Stall for 3 cycles with a pending op, then release
    exp6 = alu(OP_PMAX, rf_init_vals[6], rf_init_vals[7]);
    bus.out_ready = 1'b0;
    drive(1'b1, OP_PMAX, 3'd6, 3'd7, 1'b0, '0);
    step();
    drive(1'b1, OP_PMIN, 3'd0, 3'd1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(bus.in_ready), 64'd0);
      check("stall_data", bus.out_data, exp6);
      check("stall_dst", 64'(bus.out_dst), 64'd6);
      check("stall_count", 64'(op_count), 64'd3);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("release_count", 64'(op_count), 64'd4);
    check("release_dst", 64'(bus.out_dst), 64'd0);
    step();

    // Flush while full with a ready consumer and a waiting op
    bus.out_ready = 1'b0;
    drive(1'b1, OP_PADDW, 3'd2, 3'd1, 1'b0, '0);
    step();
    drive(1'b1, OP_MOVQ, 3'd4, 3'd0, 1'b0, '0);
    bus.out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_count", 64'(op_count), 64'd5);

    // Illegal op, then legal ops consuming its zero result
    drive(1'b1, 3'b110, 3'd7, 3'd0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    drive(1'b1, OP_PADDD, 3'd7, 3'd7, 1'b0, '0);
    @(negedge clk);
    check("illegal_data", bus.out_data, 64'h0);
    check("illegal_flag", 64'(illegal_op), 64'd1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    step();
    @(negedge clk);
    check("illegal_sticky", 64'(illegal_op), 64'd1);

    // Randomised traffic checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
            1'($urandom_range(0, 3) == 0), {$urandom, $urandom});
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    check("illegal_persist", 64'(illegal_op), 64'd1);

    // Streaming writebacks up to the counter wrap
    guard = 0;
    while (m_count != 16'hFFFF && guard < 70000) begin
      drive(1'b1, 3'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 1'($urandom), {$urandom, $urandom});
      step();
      guard++;
    end
    check("wrap_timeout", 64'(guard >= 70000), 64'd0);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("count_ffff", 64'(op_count), 64'hFFFF);
    step();
    @(negedge clk);
    check("count_wrap", 64'(op_count), 64'h0000);
    check("wrap_empty", 64'(bus.out_valid), 64'd0);

    // Reset while stalled drops the held result
    bus.out_ready = 1'b0;
    drive(1'b1, OP_PADDW, 3'd3, 3'd3, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    step();
    reset = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_data", bus.out_data, 64'h0);
    check("rst2_dst", 64'(bus.out_dst), 64'h0);
    check("rst2_illegal", 64'(illegal_op), 64'd0);
    check("rst2_count", 64'(op_count), 64'h0);
    drive(1'b1, OP_MOVQ, 3'd0, 3'd3, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    step();
    step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
